// File: rtl/control_unit_fsm_if.sv
// Control-unit bundle: encoder/condition/memory inputs and datapath strobes.
interface control_unit_fsm_if;
   logic [5:0] EncState;
   logic       CondTrue;
   logic       MOC;
   logic [5:0] State;
   logic       MARLd;
   logic       MDRLd;
   logic       IRLd;
   logic       PCLd;
   logic       RFLd;
   logic       FlagLd;
   logic       MemEn;
   logic       MemRW;
   logic       IllegalOp;
   logic       MemErr;

   // Control unit side.
   modport master (
      input  EncState, CondTrue, MOC,
      output State, MARLd, MDRLd, IRLd, PCLd, RFLd, FlagLd,
             MemEn, MemRW, IllegalOp, MemErr
   );

   // Datapath / encoder side.
   modport slave (
      output EncState, CondTrue, MOC,
      input  State, MARLd, MDRLd, IRLd, PCLd, RFLd, FlagLd,
             MemEn, MemRW, IllegalOp, MemErr
   );
endinterface

// File: rtl/control_unit_fsm.sv
// Hardwired RISC control unit: fetch, decode, execute-state dispatch,
// per-state datapath strobes, and a bounded memory-wait timeout.
module control_unit_fsm #(
   parameter int unsigned MOC_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset,
   control_unit_fsm_if.master bus
);

   localparam int unsigned STATE_W = 6;
   localparam int unsigned CNT_W   = 6;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 6'd0,
      S_FETCH1   = 6'd1,
      S_FETCH2   = 6'd2,
      S_FETCH3   = 6'd3,
      S_DECODE   = 6'd4,
      S_ADD_RR   = 6'd10,
      S_ADD_SH   = 6'd11,
      S_ADD_IMM  = 6'd12,
      S_CMP      = 6'd13,
      S_MOV      = 6'd14,
      S_LDR_ADDR = 6'd20,
      S_LDR_WAIT = 6'd21,
      S_LDR_WB   = 6'd22,
      S_STR_ADDR = 6'd25,
      S_STR_DATA = 6'd26,
      S_STR_WAIT = 6'd27,
      S_BRANCH   = 6'd30
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             enc_legal;
   logic             in_wait;
   state_e           wait_done_st;

   // Which encoder outputs name a real execute state.
   always_comb begin
      enc_legal = 1'b0;
      case (bus.EncState)
         6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
         6'd20, 6'd25, 6'd30: enc_legal = 1'b1;
         default:             enc_legal = 1'b0;
      endcase
   end

   // State, wait counter and sticky memory-error registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Next-state, wait-timeout and per-state strobe decode.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      mem_err_d     = mem_err_q;
      in_wait       = 1'b0;
      wait_done_st  = S_IDLE;
      bus.MARLd     = 1'b0;
      bus.MDRLd     = 1'b0;
      bus.IRLd      = 1'b0;
      bus.PCLd      = 1'b0;
      bus.RFLd      = 1'b0;
      bus.FlagLd    = 1'b0;
      bus.MemEn     = 1'b0;
      bus.MemRW     = 1'b0;
      bus.IllegalOp = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH1;
         S_FETCH1: begin
            bus.MARLd = 1'b1;
            state_d   = S_FETCH2;
         end
         S_FETCH2: begin
            bus.PCLd  = 1'b1;
            bus.MemEn = 1'b1;
            bus.MemRW = 1'b1;
            state_d   = S_FETCH3;
         end
         S_FETCH3: begin
            bus.MemEn    = 1'b1;
            bus.MemRW    = 1'b1;
            bus.IRLd     = bus.MOC;
            in_wait      = 1'b1;
            wait_done_st = S_DECODE;
         end
         S_DECODE: begin
            // A false condition or an unknown encoding both drop the instruction.
            if (!bus.CondTrue) begin
               state_d = S_FETCH1;
            end else if (enc_legal) begin
               state_d = state_e'(bus.EncState);
            end else begin
               bus.IllegalOp = 1'b1;
               state_d       = S_FETCH1;
            end
         end
         S_ADD_RR, S_ADD_SH, S_ADD_IMM: begin
            bus.RFLd   = 1'b1;
            bus.FlagLd = 1'b1;
            state_d    = S_FETCH1;
         end
         S_CMP: begin
            bus.FlagLd = 1'b1;
            state_d    = S_FETCH1;
         end
         S_MOV: begin
            bus.RFLd = 1'b1;
            state_d  = S_FETCH1;
         end
         S_LDR_ADDR: begin
            bus.MARLd = 1'b1;
            state_d   = S_LDR_WAIT;
         end
         S_LDR_WAIT: begin
            bus.MemEn    = 1'b1;
            bus.MemRW    = 1'b1;
            bus.MDRLd    = bus.MOC;
            in_wait      = 1'b1;
            wait_done_st = S_LDR_WB;
         end
         S_LDR_WB: begin
            bus.RFLd = 1'b1;
            state_d  = S_FETCH1;
         end
         S_STR_ADDR: begin
            bus.MARLd = 1'b1;
            state_d   = S_STR_DATA;
         end
         S_STR_DATA: begin
            bus.MDRLd = 1'b1;
            state_d   = S_STR_WAIT;
         end
         S_STR_WAIT: begin
            bus.MemEn    = 1'b1;
            bus.MemRW    = 1'b0;
            in_wait      = 1'b1;
            wait_done_st = S_FETCH1;
         end
         S_BRANCH: begin
            bus.PCLd = 1'b1;
            state_d  = S_FETCH1;
         end
         default: state_d = S_IDLE;
      endcase

      // Memory wait: MOC completes; otherwise count, aborting at the limit.
      if (in_wait) begin
         if (bus.MOC) begin
            state_d = wait_done_st;
         end else if (wait_cnt_q == CNT_LAST) begin
            state_d   = S_IDLE;
            mem_err_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   assign bus.State  = state_q;
   assign bus.MemErr = mem_err_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: per-cycle expected state and
// strobes are queued as stimulus is applied and compared one cycle at a time.
module tb_control_unit_fsm;

   logic Clk = 1'b0;
   logic Reset;
   control_unit_fsm_if bus();

   control_unit_fsm #(.MOC_TIMEOUT(15)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit         rst;
      bit         moc;
      bit         cond;
      logic [5:0] enc;
      logic [5:0] st;
      bit         ill;
      bit         err;
   } cyc_t;

   cyc_t        stim_q[$];
   logic [15:0] sb_q[$];
   int          total = 0;
   int          bad   = 0;

   wire [15:0] obs_v = {bus.State, bus.MARLd, bus.MDRLd, bus.IRLd, bus.PCLd,
                        bus.RFLd, bus.FlagLd, bus.MemEn, bus.MemRW,
                        bus.IllegalOp, bus.MemErr};

   // Strobes the spec assigns to a state, given MOC and the expected flags.
   function automatic logic [9:0] outs(input logic [5:0] st, input bit moc,
                                       input bit ill, input bit err);
      logic mar, mdr, ir, pc, rf, fl, men, mrw, il;
      mar = 0; mdr = 0; ir = 0; pc = 0; rf = 0; fl = 0; men = 0; mrw = 0; il = 0;
      case (st)
         6'd1:  mar = 1;
         6'd2:  begin pc = 1; men = 1; mrw = 1; end
         6'd3:  begin men = 1; mrw = 1; ir = moc; end
         6'd4:  il = ill;
         6'd10, 6'd11, 6'd12: begin rf = 1; fl = 1; end
         6'd13: fl = 1;
         6'd14: rf = 1;
         6'd20, 6'd25: mar = 1;
         6'd21: begin men = 1; mrw = 1; mdr = moc; end
         6'd22: rf = 1;
         6'd26: mdr = 1;
         6'd27: men = 1;
         6'd30: pc = 1;
         default: ;
      endcase
      return {mar, mdr, ir, pc, rf, fl, men, mrw, il, err};
   endfunction

   function automatic void add(input int n, input logic [5:0] st, input bit moc,
                               input bit cond, input logic [5:0] enc,
                               input bit ill = 0, input bit err = 0,
                               input bit rst = 0);
      cyc_t c;
      c.rst = rst; c.moc = moc; c.cond = cond; c.enc = enc;
      c.st = st; c.ill = ill; c.err = err;
      for (int i = 0; i < n; i++) stim_q.push_back(c);
   endfunction

   task automatic drive(input cyc_t c);
      @(negedge Clk);
      Reset        = c.rst;
      bus.MOC      = c.moc;
      bus.CondTrue = c.cond;
      bus.EncState = c.enc;
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset   = 1'b1;
      bus.MOC = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      cyc_t c; logic [15:0] e; int k = 0;
      add(2, 6'd0, 1, 1, 6'd10, 0, 0, 1);
      add(1, 6'd0, 1, 1, 6'd10);
      add(1, 6'd1, 1, 1, 6'd10);
      add(1, 6'd2, 1, 1, 6'd10);
      add(1, 6'd3, 1, 1, 6'd10);
      add(1, 6'd4, 1, 1, 6'd10);
      add(1, 6'd10, 1, 1, 6'd10);
      add(1, 6'd1, 1, 1, 6'd10);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL reset cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_add_imm();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      // EncState only matters in decode; garbage elsewhere must be ignored.
      add(1, 6'd0, 1, 1, 6'd5);
      add(1, 6'd1, 1, 1, 6'd5);
      add(1, 6'd2, 1, 1, 6'd5);
      add(1, 6'd3, 1, 1, 6'd5);
      add(1, 6'd4, 1, 1, 6'd12);
      add(1, 6'd12, 1, 1, 6'd5);
      add(1, 6'd1, 1, 1, 6'd5);
      add(1, 6'd2, 1, 1, 6'd5);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL add_imm cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_ldr();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 1, 6'd20);
      add(1, 6'd1, 1, 1, 6'd20);
      add(1, 6'd2, 1, 1, 6'd20);
      add(1, 6'd3, 1, 1, 6'd20);
      add(1, 6'd4, 1, 1, 6'd20);
      add(1, 6'd20, 0, 1, 6'd20);
      add(2, 6'd21, 0, 1, 6'd20);
      add(1, 6'd21, 1, 1, 6'd20);
      add(1, 6'd22, 1, 1, 6'd20);
      add(1, 6'd1, 1, 1, 6'd20);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL ldr cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_cond_illegal();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 0, 6'd30);
      add(1, 6'd1, 1, 0, 6'd30);
      add(1, 6'd2, 1, 0, 6'd30);
      add(1, 6'd3, 1, 0, 6'd30);
      add(1, 6'd4, 1, 0, 6'd30);
      add(1, 6'd1, 1, 1, 6'd5);
      add(1, 6'd2, 1, 1, 6'd5);
      add(1, 6'd3, 1, 1, 6'd5);
      add(1, 6'd4, 1, 1, 6'd5, 1);
      add(1, 6'd1, 1, 1, 6'd5);
      add(1, 6'd2, 1, 1, 6'd5);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL cond_illegal cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 1, 6'd30);
      add(1, 6'd1, 1, 1, 6'd30);
      add(1, 6'd2, 1, 1, 6'd30);
      add(2, 6'd3, 0, 1, 6'd30);
      add(1, 6'd3, 1, 1, 6'd30);
      add(1, 6'd4, 1, 1, 6'd30);
      add(1, 6'd30, 1, 1, 6'd13);
      add(1, 6'd1, 1, 1, 6'd13);
      add(1, 6'd2, 1, 1, 6'd13);
      add(1, 6'd3, 1, 1, 6'd13);
      add(1, 6'd4, 1, 1, 6'd13);
      add(1, 6'd13, 1, 1, 6'd14);
      add(1, 6'd1, 1, 1, 6'd14);
      add(1, 6'd2, 1, 1, 6'd14);
      add(1, 6'd3, 1, 1, 6'd14);
      add(1, 6'd4, 1, 1, 6'd14);
      add(1, 6'd14, 1, 1, 6'd11);
      add(1, 6'd1, 1, 1, 6'd11);
      add(1, 6'd2, 1, 1, 6'd11);
      add(1, 6'd3, 1, 1, 6'd11);
      add(1, 6'd4, 1, 1, 6'd11);
      add(1, 6'd11, 1, 1, 6'd11);
      add(1, 6'd1, 1, 1, 6'd11);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL back_to_back cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_moc_at_limit();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 1, 6'd25);
      add(1, 6'd1, 1, 1, 6'd25);
      add(1, 6'd2, 1, 1, 6'd25);
      add(1, 6'd3, 1, 1, 6'd25);
      add(1, 6'd4, 1, 1, 6'd25);
      add(1, 6'd25, 1, 1, 6'd25);
      add(1, 6'd26, 1, 1, 6'd25);
      add(14, 6'd27, 0, 1, 6'd25);
      add(1, 6'd27, 1, 1, 6'd25);
      add(1, 6'd1, 1, 1, 6'd25);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL moc_at_limit cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_str_timeout();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 1, 6'd25);
      add(1, 6'd1, 1, 1, 6'd25);
      add(1, 6'd2, 1, 1, 6'd25);
      add(1, 6'd3, 1, 1, 6'd25);
      add(1, 6'd4, 1, 1, 6'd25);
      add(1, 6'd25, 1, 1, 6'd25);
      add(1, 6'd26, 1, 1, 6'd25);
      add(15, 6'd27, 0, 1, 6'd10);
      add(1, 6'd0, 1, 1, 6'd10, 0, 1);
      add(1, 6'd1, 1, 1, 6'd10, 0, 1);
      add(1, 6'd2, 1, 1, 6'd10, 0, 1);
      add(1, 6'd3, 1, 1, 6'd10, 0, 1);
      add(1, 6'd4, 1, 1, 6'd10, 0, 1);
      add(1, 6'd10, 1, 1, 6'd10, 0, 1);
      add(1, 6'd1, 1, 1, 6'd10, 0, 1);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL str_timeout cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
      // Only reset clears the sticky error.
      do_reset();
      add(1, 6'd0, 1, 1, 6'd10);
      add(1, 6'd1, 1, 1, 6'd10);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL err_clear cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid_wait();
      cyc_t c; logic [15:0] e; int k = 0;
      do_reset();
      add(1, 6'd0, 1, 1, 6'd20);
      add(1, 6'd1, 1, 1, 6'd20);
      add(1, 6'd2, 1, 1, 6'd20);
      add(1, 6'd3, 1, 1, 6'd20);
      add(1, 6'd4, 1, 1, 6'd20);
      add(1, 6'd20, 0, 1, 6'd20);
      add(2, 6'd21, 0, 1, 6'd20);
      add(1, 6'd21, 0, 1, 6'd20, 0, 0, 1);
      add(1, 6'd0, 0, 1, 6'd20);
      while (stim_q.size() > 0) begin
         c = stim_q.pop_front();
         sb_q.push_back({c.st, outs(c.st, c.moc, c.ill, c.err)});
         drive(c);
         e = sb_q.pop_front();
         total++;
         if (obs_v !== e) begin
            bad++;
            $display("FAIL reset_mid_wait cyc%0d got=%h want=%h", k, obs_v, e);
         end
         k++;
      end
      total++;
      if (dut.wait_cnt_q !== 6'd0) begin
         bad++;
         $display("FAIL reset_mid_wait_cnt got=%0d want=0", dut.wait_cnt_q);
      end
   endtask

   initial begin
      Reset        = 1'b1;
      bus.MOC      = 1'b1;
      bus.CondTrue = 1'b1;
      bus.EncState = 6'd10;
      test_reset();
      test_add_imm();
      test_ldr();
      test_cond_illegal();
      test_back_to_back();
      test_moc_at_limit();
      test_str_timeout();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_unit_fsm.md
# control_unit_fsm

Hardwired control state machine for the RISC datapath, sitting directly downstream of the instruction encoder. It sequences fetch and decode, then jumps to the 6-bit execute state number the encoder produces from the instruction register. It drives the per-state datapath load and memory strobes, and returns to fetch when each instruction completes. It also bounds every memory wait with a timeout counter and flags illegal encoder outputs.

## Interface
- MOC_TIMEOUT, 15: maximum consecutive cycles with MOC low in any memory-wait state before abort (1..63).
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- EncState  in  6  execute state number from the instruction encoder (10,11,12,13,14,20,25,30 legal).
- CondTrue  in  1  condition tester result for the current IR; sampled in state 4 only.
- MOC  in  1  memory operation complete; sampled in states 3, 21, 27.
- State  out  6  current state number.
- MARLd, MDRLd, IRLd, PCLd, RFLd, FlagLd  out  1 each  datapath register load enables.
- MemEn  out  1  memory request active.
- MemRW  out  1  1 = read, 0 = write; meaningful only when MemEn=1.
- IllegalOp  out  1  one-cycle pulse when decode sees an illegal EncState.
- MemErr  out  1  sticky flag set on MOC timeout; cleared only by Reset.

## Operation
- Reset: State=0, WaitCnt=0, MemErr=0. All load enables, MemEn, MemRW and IllegalOp are 0. Reset overrides every other event, including mid-instruction and mid-wait.
- Outputs are decoded from State. IRLd and MDRLd are additionally qualified by MOC as noted.
- State sequence:
  - 0 Idle: no outputs; next 1.
  - 1 Fetch1: MARLd=1 (MAR<-PC); next 2.
  - 2 Fetch2: PCLd=1 (PC<-PC+4), MemEn=1, MemRW=1; next 3.
  - 3 Fetch3: MemEn=1, MemRW=1, IRLd=MOC. If MOC=1, next 4; otherwise stay.
  - 4 Decode: no loads.
    - CondTrue=0: next 1 (instruction skipped).
    - CondTrue=1 and EncState legal: next EncState.
    - CondTrue=1 and EncState illegal: IllegalOp=1, next 1.
  - 10 ADD R-R, 11 ADD shift, 12 ADD imm, 14 MOV: RFLd=1 and FlagLd=1 (FlagLd=0 for 14); next 1.
  - 13 CMP: FlagLd=1, RFLd=0; next 1.
  - 20 LDR addr: MARLd=1; next 21.
  - 21 LDR wait: MemEn=1, MemRW=1, MDRLd=MOC. If MOC=1, next 22; otherwise stay.
  - 22 LDR wb: RFLd=1; next 1.
  - 25 STR addr: MARLd=1; next 26.
  - 26 STR data: MDRLd=1; next 27.
  - 27 STR wait: MemEn=1, MemRW=0. If MOC=1, next 1; otherwise stay.
  - 30 B: PCLd=1 (PC<-PC+offset); next 1.
  - Any other State value (unreachable): next 0.
- Timeout counter WaitCnt (6 bits):
  - Increments each cycle spent in 3/21/27 with MOC=0.
  - Clears on any transition and whenever MOC=1.
  - If MOC=0 and WaitCnt==MOC_TIMEOUT-1: next state 0, MemErr<=1. The current cycle still drives that wait state's outputs.
  - MOC=1 in the same cycle as the limit: MOC wins and the normal transition is taken.
- MemErr stays 1 through subsequent instructions; the FSM keeps running (0 -> 1 ...).
- EncState is sampled only in state 4. Changes in other states have no effect.

## Timing
- State is registered; outputs are valid in the same cycle State shows the value.
- Minimum fetch+decode is 4 cycles (states 1,2,3,4), with MOC=1 on the first cycle of state 3. Each MOC-low cycle adds one.
- Total cycles per instruction with zero memory wait:
  - ADD/CMP/MOV/B: 5.
  - LDR: 7.
  - STR: 7.
  - Condition-false or illegal: 4.
- IRLd/MDRLd are asserted in exactly the cycle MOC=1 is seen in the wait state, never earlier.
- First cycle after Reset deasserts: State=0; State=1 on the following cycle.

## Test plan
- Reset: hold Reset 2 cycles with MOC=1 and EncState=10 -> State=0, all outputs 0, MemErr=0; after release State goes 0,1,2,3,4,10,1.
- ADD immediate, CondTrue=1, EncState=12, MOC=1 always -> RFLd=1 and FlagLd=1 only in the state-12 cycle; IRLd=1 only in state 3; 5 cycles fetch-to-fetch.
- LDR with MOC low for 2 cycles in state 21, EncState=20 -> States 20,21,21,21,22,1; MDRLd=1 only on the third state-21 cycle; RFLd=1 in 22.
- CondTrue=0 with EncState=30 -> 4 then 1, no PCLd in state 4. EncState=5 with CondTrue=1 -> IllegalOp=1 for exactly one cycle, then State=1.
- MOC held 0 in state 27 (STR), MOC_TIMEOUT=15 -> 15 cycles in state 27, then State=0 and MemErr=1. MemErr stays 1 through the next full ADD; it clears only after Reset.
- Reset asserted during state 21 with MOC=0 -> next State=0, WaitCnt=0, MemEn=0.
